pipelined_multiplier: RTL and testbench
=======================================

Name: pipelined_multiplier

Overview:
Parametrised, fully pipelined integer multiplier. It is the next-generation replacement for the single-cycle direct multiplier in the CORDIC multiplier comparison flow. It accepts one operand pair per cycle through a valid/ready handshake and supports signed or unsigned operation per transaction. It returns the full-width product after a configurable latency, honours downstream backpressure and carries a user tag alongside each result.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
LATENCY, 3, cycles from input acceptance to out_valid with no stall (>=1)
TAG_W, 4, width of the user tag carried alongside each operation (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
in_signed  in  1  1 = two's-complement operands, 0 = unsigned
in_x  in  WIDTH  multiplicand
in_z  in  WIDTH  multiplier
in_tag  in  TAG_W  user tag, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_y  out  2*WIDTH  product
out_tag  out  TAG_W  tag of this result
busy  out  1  any stage holds a valid entry

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits are 0, so out_valid=0 and busy=0. out_y=0, out_tag=0, and all data registers are 0. in_ready is 1 after reset.
- Accept: a transaction is accepted when in_valid && in_ready on a rising clk edge.
- Arithmetic:
  - in_signed=1: sign-extend both operands to 2*WIDTH bits.
  - in_signed=0: zero-extend both operands.
  - Product is the exact 2*WIDTH-bit result; no truncation or saturation.
  - Signed -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2). This is representable and must be correct.
- Pipeline:
  - LATENCY register stages; each stage holds {valid, product, tag}.
  - The product is formed in stage 0. Later stages are pure delay, which retiming may redistribute.
  - With no stall, an op accepted at edge N shows out_valid=1 and its result after edge N+LATENCY-1.
  - Effective latency is LATENCY cycles, measured from the accept cycle to the first cycle out_valid is high.
- Stall (global): stall = out_valid && !out_ready.
  - While stall, every stage holds its contents.
  - in_ready = !stall.
  - Bubbles are not compressed.
- Output: out_valid, out_y and out_tag come directly from the last stage.
  - They stay stable while out_valid && !out_ready.
  - When out_valid=0, out_y and out_tag retain their last value; the bench must not check them.
- Throughput: one result per cycle with out_ready held at 1.
- Ordering: results leave in acceptance order; tags are never reordered.
- busy = OR of all stage valid bits.
- flush (synchronous, highest priority):
  - Clears all stage valid bits on the next edge.
  - A transaction presented in the same cycle as flush is dropped, even though in_ready=1.
  - Data registers are not required to clear.
- Simultaneous events:
  - Stall with in_valid high: the op is not accepted; the source must hold it (in_ready=0).
  - out_ready rising in the same cycle as a new in_valid: the pipeline advances and the new op is accepted.
- Reset mid-operation: all in-flight ops are lost. No result appears after rst_n is released unless a new transaction is accepted.
- LATENCY=1: product registered straight into the output stage; in_ready = !(out_valid && !out_ready).

Decomposition:
- Shared package mult_pkg:
  - default WIDTH, LATENCY and TAG_W constants
  - function sext_or_zext(value, is_signed), for reuse by the CORDIC and approximate multiplier wrappers
  - localparam PROD_W = 2*WIDTH
- One sub-module is natural: mult_pipe_stage, a single {valid, data, tag} register with hold/flush control.
  - The top level instantiates it LATENCY times via generate.
  - Stage 0 is fed from the extended-operand product.

Test Plan:
- WIDTH=8, LATENCY=3, signed:
  - x=-3 (0xFD), z=5, tag=0x2 -> out_y=0xFFF1, out_tag=0x2, out_valid exactly 3 cycles after accept.
  - x=-128, z=-128 -> 0x4000.
  - x=127, z=-128 -> 0xC080.
- Unsigned: x=0xFD, z=0x05 -> out_y=0x04F1; x=0xFF, z=0xFF -> 0xFE01; 0x00 * anything -> 0x0000.
- Streaming: 16 back-to-back random ops, out_ready=1 -> 16 results on consecutive cycles, in order, matching a reference model with tags 0..15.
- Backpressure:
  - out_ready=0 for 5 cycles while 4 ops are issued -> in_ready drops once out_valid is 1, and out_y/out_tag hold.
  - Release out_ready -> remaining results drain in order with no loss or duplication.
- flush:
  - Assert for 1 cycle with 2 ops in flight and in_valid=1 -> busy=0 next cycle; none of the 3 ops is ever output.
  - A following op completes normally.
- Async reset: pulse rst_n low mid-stream (between clk edges) -> out_valid=0 and busy=0 immediately; in_ready=1 after release; no stale results.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier family (pipelined, CORDIC and
// approximate wrappers).
//   WIDTH_DEF / LATENCY_DEF / TAG_W_DEF : default build parameters
//   PROD_W                              : product width for the default WIDTH
//   EXT_MAX_W                           : widest operand sext_or_zext handles
//   sext_or_zext(value, width, signed)  : extend a width-bit operand to
//                                         2*EXT_MAX_W bits, sign or zero fill
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int LATENCY_DEF = 3;
  localparam int TAG_W_DEF   = 4;
  localparam int PROD_W      = 2 * WIDTH_DEF;
  localparam int EXT_MAX_W   = 32;

  // The operand arrives right-aligned in a EXT_MAX_W container; every bit at
  // or above 'width' is replaced by the fill bit, so stray upper bits in the
  // container never leak into the result.
  function automatic logic [2*EXT_MAX_W-1:0] sext_or_zext(
    input logic [EXT_MAX_W-1:0] value,
    input int                   width,
    input logic                 is_signed
  );
    logic [2*EXT_MAX_W-1:0] r;
    logic                   fill;
    r    = {{EXT_MAX_W{1'b0}}, value};
    fill = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == width - 1) fill = is_signed & value[i];
    end
    for (int i = 0; i < 2*EXT_MAX_W; i++) begin
      if (i >= width) r[i] = fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipelined_multiplier_if.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier_if
// Operand / result handshake bundle of the pipelined multiplier.
//   in_valid/in_ready, in_signed, in_x, in_z, in_tag : operand channel
//   out_valid/out_ready, out_y, out_tag              : result channel
// master : the side that issues operands and consumes results
// slave  : the multiplier
// -----------------------------------------------------------------------------
interface pipelined_multiplier_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_z;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_y;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_signed, in_x, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );
endinterface

// File: rtl/mult_pipe_stage.sv
// -----------------------------------------------------------------------------
// mult_pipe_stage
// One {valid, data, tag} pipeline register.
//   clk, rst_n      : clock, asynchronous active-low reset (clears everything)
//   i_flush         : synchronous clear of the valid bit, wins over hold
//   i_hold          : keep current contents (global stall)
//   i_vld/i_data/i_tag : upstream entry
//   o_vld/o_data/o_tag : registered entry
// Data and tag only load with a valid entry, so they keep the last result
// while the stage is empty.
// -----------------------------------------------------------------------------
module mult_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag
);

  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic [TAG_W-1:0]  r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
    end else if (i_flush) begin
      r_vld  <= 1'b0;
    end else if (!i_hold) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_data <= i_data;
        r_tag  <= i_tag;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_tag  = r_tag;

endmodule

// File: rtl/pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier
// Fully pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per
// transaction, with a user tag carried alongside each product.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear of every in-flight entry (drops the op
//                presented in the same cycle)
//   bus        : operand/result handshake (slave side)
//   busy       : some stage holds a valid entry
// The product is formed combinationally ahead of stage 0; stages 1..LATENCY-1
// are pure delay that retiming may pull into the multiplier. A stalled output
// (out_valid && !out_ready) freezes every stage, bubbles included.
// -----------------------------------------------------------------------------
module pipelined_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  pipelined_multiplier_if.slave  bus,
  output logic                   busy
);

  localparam int PW = 2 * WIDTH;

  logic [2*EXT_MAX_W-1:0] w_x_wide;
  logic [2*EXT_MAX_W-1:0] w_z_wide;
  logic signed [PW-1:0]   w_x_ext_p0;
  logic signed [PW-1:0]   w_z_ext_p0;
  logic signed [PW-1:0]   w_prod_p0;
  logic                   w_stall;

  // Both operands are extended to the full product width, so a plain
  // PW-bit modular product is exact for signed and unsigned alike,
  // including -2^(WIDTH-1) squared.
  assign w_x_wide   = sext_or_zext(EXT_MAX_W'(bus.in_x), WIDTH, bus.in_signed);
  assign w_z_wide   = sext_or_zext(EXT_MAX_W'(bus.in_z), WIDTH, bus.in_signed);
  assign w_x_ext_p0 = signed'(w_x_wide[PW-1:0]);
  assign w_z_ext_p0 = signed'(w_z_wide[PW-1:0]);
  assign w_prod_p0  = w_x_ext_p0 * w_z_ext_p0;

  generate
    if (PW < 2*EXT_MAX_W) begin : g_ext_upper
      logic w_unused_ext;
      assign w_unused_ext = ^{w_x_wide[2*EXT_MAX_W-1:PW], w_z_wide[2*EXT_MAX_W-1:PW]};
    end
  endgenerate

  // Index 0 is the stage-0 input; index k is the output of stage k-1.
  logic [LATENCY:0]           w_vld;
  logic [LATENCY:0][PW-1:0]   w_data;
  logic [LATENCY:0][TAG_W-1:0] w_tag;

  assign w_vld[0]  = bus.in_valid;
  assign w_data[0] = w_prod_p0;
  assign w_tag[0]  = bus.in_tag;

  // Global stall: nothing moves while the head result waits downstream.
  assign w_stall = w_vld[LATENCY] & ~bus.out_ready;

  // ---- stage boundaries p0 .. p(LATENCY-1) ----
  generate
    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
      mult_pipe_stage #(
        .DATA_W (PW),
        .TAG_W  (TAG_W)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_hold  (w_stall),
        .i_vld   (w_vld[g]),
        .i_data  (w_data[g]),
        .i_tag   (w_tag[g]),
        .o_vld   (w_vld[g+1]),
        .o_data  (w_data[g+1]),
        .o_tag   (w_tag[g+1])
      );
    end
  endgenerate

  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = w_vld[LATENCY];
  assign bus.out_y     = w_data[LATENCY];
  assign bus.out_tag   = w_tag[LATENCY];
  assign busy          = |w_vld[LATENCY:1];

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;

  localparam int W = 8;
  localparam int L = 3;
  localparam int T = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic busy;

  pipelined_multiplier_if #(.WIDTH(W), .TAG_W(T)) bus ();

  pipelined_multiplier #(.WIDTH(W), .LATENCY(L), .TAG_W(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int stall_cnt = 0;
  int out_cyc[$];

  typedef struct {
    logic [2*W-1:0] y;
    logic [T-1:0]   tag;
    int             age;   // stages advanced since acceptance
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input bit s, input logic [W-1:0] x, input logic [W-1:0] z);
    int a, b, p;
    a = int'(x);
    b = int'(z);
    if (s && a >= (1 << (W-1))) a = a - (1 << W);
    if (s && b >= (1 << (W-1))) b = b - (1 << W);
    p = a * b;
    return p[2*W-1:0];
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: runs mid-cycle, checks the DUT against the queue model,
  // then advances the model to what the coming edge must do.
  logic           held = 1'b0;
  logic [2*W-1:0] held_y;
  logic [T-1:0]   held_tag;

  always @(negedge clk) begin : mon
    logic exp_ov;
    logic stall;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      exp_ov = (q.size() > 0) && (q[0].age == L-1);
      stall  = exp_ov && !bus.out_ready;
      chk("out_valid", bus.out_valid, exp_ov);
      chk("busy", busy, q.size() > 0);
      chk("in_ready", bus.in_ready, !stall);
      if (exp_ov && bus.out_valid) begin
        chk("out_y", bus.out_y, q[0].y);
        chk("out_tag", bus.out_tag, q[0].tag);
        if (held) begin
          chk("hold_y", bus.out_y, held_y);
          chk("hold_tag", bus.out_tag, held_tag);
        end
      end
      held     = stall && !flush;
      held_y   = bus.out_y;
      held_tag = bus.out_tag;
      if (stall) stall_cnt++;
      if (flush) begin
        q.delete();
      end else if (!stall) begin
        if (exp_ov) begin
          void'(q.pop_front());
          out_cyc.push_back(cyc);
        end
        foreach (q[i]) q[i].age++;
        if (bus.in_valid)
          q.push_back('{ref_prod(bus.in_signed, bus.in_x, bus.in_z), bus.in_tag, 0});
      end
    end
  end

  // Present one op and hold it until accepted; returns at accept edge + 1.
  task automatic send(input bit s, input logic [W-1:0] x, input logic [W-1:0] z, input logic [T-1:0] tag);
    bit acc;
    int t;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_x      = x;
    bus.in_z      = z;
    bus.in_tag    = tag;
    t = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      t++;
      if (!acc) begin
        @(posedge clk);
        #1;
      end
    end while (!acc && t < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input bit s, input logic [W-1:0] x, input logic [W-1:0] z,
                          input logic [T-1:0] tag, input logic [2*W-1:0] exp_y);
    int lat;
    chk({name, "_model"}, ref_prod(s, x, z), exp_y);
    send(s, x, z, tag);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_latency"}, lat, L);
    chk({name, "_y"}, bus.out_y, exp_y);
    chk({name, "_tag"}, bus.out_tag, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int  n0;
    int  s0;
    bit  acc;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_x      = '0;
    bus.in_z      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_y", bus.out_y, 16'h0000);
    chk("rst_out_tag", bus.out_tag, 4'h0);
    #1 rst_n = 1'b1;
    idle(2);

    // Hand-computed products
    directed("s_m3x5",     1'b1, 8'hFD, 8'h05, 4'h2, 16'hFFF1);
    directed("s_min_sq",   1'b1, 8'h80, 8'h80, 4'h5, 16'h4000);
    directed("s_max_min",  1'b1, 8'h7F, 8'h80, 4'h9, 16'hC080);
    directed("u_fdx05",    1'b0, 8'hFD, 8'h05, 4'h3, 16'h04F1);
    directed("u_ffxff",    1'b0, 8'hFF, 8'hFF, 4'hE, 16'hFE01);
    directed("u_zero",     1'b0, 8'h00, 8'hA7, 4'h1, 16'h0000);
    idle(3);

    // Streaming: 16 back-to-back ops, tags 0..15
    out_cyc.delete();
    for (int i = 0; i < 16; i++)
      send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), T'(i));
    idle(L + 3);
    chk("stream_count", out_cyc.size(), 16);
    if (out_cyc.size() == 16) chk("stream_span", out_cyc[15] - out_cyc[0], 15);

    // Backpressure: out_ready low for 5 cycles while 4 ops are issued
    out_cyc.delete();
    s0 = stall_cnt;
    bus.out_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++)
        send(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), T'(8 + i));
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle(L + 4);
    chk("bp_stalled", (stall_cnt - s0) > 0, 1'b1);
    chk("bp_drained", out_cyc.size(), 4);
    chk("bp_empty", q.size(), 0);

    // Flush with two ops in flight and a third presented
    out_cyc.delete();
    send(1'b0, 8'h11, 8'h22, 4'hA);
    send(1'b1, 8'h33, 8'hC4, 4'hB);
    bus.in_valid  = 1'b1;
    bus.in_x      = 8'h44;
    bus.in_z      = 8'h55;
    bus.in_tag    = 4'hC;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    idle(L + 2);
    chk("flush_no_output", out_cyc.size(), 0);
    directed("after_flush", 1'b1, 8'hF0, 8'h10, 4'h7, 16'hFF00);
    idle(2);

    // Async reset between edges with ops in flight
    send(1'b0, 8'h12, 8'h34, 4'h1);
    send(1'b0, 8'h56, 8'h78, 4'h2);
    out_cyc.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    #9 rst_n = 1'b1;
    #1;
    chk("arst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    idle(L + 3);
    chk("arst_no_stale", out_cyc.size(), 0);

    // Random traffic with random backpressure and occasional flush
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.in_signed = 1'($urandom_range(0, 1));
        bus.in_x      = W'($urandom);
        bus.in_z      = W'($urandom);
        bus.in_tag    = T'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      acc = bus.in_ready || flush;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    n0 = 0;
    while (q.size() != 0 && n0 < 20) begin
      idle(1);
      n0++;
    end
    chk("random_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
